// File: rtl/lifo_drain_ctrl.sv
// LIFO drain controller: pops a burst from the stack and streams it out.
// A credit-limited buffer absorbs stack read latency under back-pressure.
module lifo_drain_ctrl #(
  parameter int WIDTH  = 8,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             stk_empty,
  output logic             stk_read,
  input  logic [WIDTH-1:0] stk_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] popped_cnt
);

  localparam int DEPTH = RD_LAT + 2;
  localparam int PW    = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int OW    = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] rem_q;
  logic             unlim_q;
  logic [CNT_W-1:0] pcnt_q;
  logic             done_q;
  logic [OW-1:0]    infl_q;
  logic [OW-1:0]    occ_q;
  logic [PW-1:0]    wp_q;
  logic [PW-1:0]    rp_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic rd;
  logic ret;
  logic deq;
  logic credit;
  logic more;
  logic last_pop;
  logic fin;

  // Credit counts only registered state, so a same-cycle dequeue earns nothing.
  assign credit = ({1'b0, infl_q} + {1'b0, occ_q}) < (OW+1)'(DEPTH);
  assign more   = unlim_q || (rem_q != '0);
  assign rd     = !reset && (state_q == DRAIN) && !stk_empty
                  && more && credit;

  assign last_pop = !unlim_q && ((rem_q - CNT_W'(rd)) == '0);
  assign deq      = out_valid && out_ready;
  assign fin      = (infl_q == '0)
                    && ((occ_q == '0) || ((occ_q == OW'(1)) && deq));

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = DRAIN;
      DRAIN: if (last_pop || (stk_empty && !rd)) state_d = FLUSH;
      FLUSH: if (fin) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stk_read = rd;
    busy     = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q   <= '0;
      unlim_q <= 1'b0;
      pcnt_q  <= '0;
      done_q  <= 1'b0;
      infl_q  <= '0;
    end else begin
      done_q <= (state_q == FLUSH) && fin;
      infl_q <= infl_q + OW'(rd) - OW'(ret);
      if (state_q == IDLE && start) begin
        rem_q   <= burst_len;
        unlim_q <= (burst_len == '0);
        pcnt_q  <= '0;
      end else if (rd) begin
        if (!unlim_q) rem_q <= rem_q - CNT_W'(1);
        if (pcnt_q != '1) pcnt_q <= pcnt_q + CNT_W'(1);
      end
    end
  end

  // Tag line marks the cycle each popped word shows up on stk_data.
  if (RD_LAT == 0) begin : g_lat0
    assign ret = rd;
  end else begin : g_lat
    logic [RD_LAT-1:0] tag_q;
    always_ff @(posedge clk) begin
      if (reset) begin
        tag_q <= '0;
      end else begin
        tag_q[0] <= rd;
        for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
      end
    end
    assign ret = tag_q[RD_LAT-1];
  end

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      occ_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (ret) begin
        mem_q[wp_q] <= stk_data;
        wp_q        <= bump(wp_q);
      end
      if (deq) rp_q <= bump(rp_q);
      occ_q <= occ_q + OW'(ret) - OW'(deq);
    end
  end

  assign out_valid  = (occ_q != '0);
  assign out_data   = mem_q[rp_q];
  assign done       = done_q;
  assign popped_cnt = pcnt_q;

endmodule

// File: tb/tb_lifo_drain_ctrl.sv
// Bench for lifo_drain_ctrl: two instances (RD_LAT 1 and 3) fed by a
// stack model; outputs checked each cycle against an expected-word queue.
module tb_lifo_drain_ctrl;

  localparam int W    = 8;
  localparam int CW   = 4;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]    start, stk_empty, stk_read, out_valid, out_ready;
  logic [1:0]    busy, done;
  logic [CW-1:0] blen [2];
  logic [CW-1:0] pcnt [2];
  logic [W-1:0]  stk_data [2];
  logic [W-1:0]  out_data [2];

  lifo_drain_ctrl #(.WIDTH(W), .RD_LAT(LAT0), .CNT_W(CW)) u_dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .burst_len(blen[0]),
    .stk_empty(stk_empty[0]), .stk_read(stk_read[0]),
    .stk_data(stk_data[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0]),
    .done(done[0]), .popped_cnt(pcnt[0])
  );

  lifo_drain_ctrl #(.WIDTH(W), .RD_LAT(LAT1), .CNT_W(CW)) u_dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .burst_len(blen[1]),
    .stk_empty(stk_empty[1]), .stk_read(stk_read[1]),
    .stk_data(stk_data[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1]),
    .done(done[1]), .popped_cnt(pcnt[1])
  );

  // Stack model: 8-deep LIFO with a data delay line per lane.
  logic [W-1:0] stk [2][8];
  int           sp [2] = '{0, 0};
  logic [1:0]   push_en;
  logic [W-1:0] push_val [2];
  logic [W-1:0] dly [2][4];
  logic [3:0]   dtag [2];

  assign stk_empty   = {sp[1] == 0, sp[0] == 0};
  assign stk_data[0] = dly[0][LAT0-1];
  assign stk_data[1] = dly[1][LAT1-1];

  always @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (stk_read[l] && sp[l] > 0) begin
        dly[l][0] <= stk[l][sp[l]-1];
        sp[l]     <= sp[l] - 1;
      end else begin
        dly[l][0] <= 8'hEE;
        if (push_en[l] && sp[l] < 8) begin
          stk[l][sp[l]] <= push_val[l];
          sp[l]         <= sp[l] + 1;
        end
      end
      for (int k = 1; k < 4; k++) dly[l][k] <= dly[l][k-1];
      dtag[l] <= reset ? 4'b0 : {dtag[l][2:0], stk_read[l]};
    end
  end

  int vec = 0;
  int miss = 0;

  task automatic chk(input string nm, input bit ok,
                     input int act, input int req);
    vec++;
    if (!ok) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  logic [W-1:0] exp_q [2][$];
  logic [W-1:0] got [2][$];
  int           occ_m [2];
  int           rds [2];
  int           dones [2];
  logic         stall [2];
  logic [W-1:0] last_d [2];

  always @(negedge clk) begin
    for (int l = 0; l < 2; l++) begin
      logic r;
      logic dq;
      int   cap;
      logic [W-1:0] w;
      r   = (l == 0) ? dtag[0][LAT0-1] : dtag[1][LAT1-1];
      cap = (l == 0) ? LAT0 + 2 : LAT1 + 2;
      if (reset) begin
        occ_m[l] = 0;
        stall[l] = 1'b0;
        exp_q[l].delete();
      end else begin
        dq = out_valid[l] && out_ready[l];
        chk("out_valid", out_valid[l] == (occ_m[l] != 0),
            out_valid[l], occ_m[l] != 0);
        chk("occupancy", occ_m[l] <= cap, occ_m[l], cap);
        if (stall[l])
          chk("stall_data", out_data[l] == last_d[l],
              out_data[l], last_d[l]);
        if (stk_read[l]) begin
          rds[l]++;
          chk("read_on_empty", !stk_empty[l], stk_empty[l], 0);
        end
        if (done[l]) dones[l]++;
        if (dq) begin
          chk("extra_word", exp_q[l].size() > 0, out_data[l], 0);
          if (exp_q[l].size() > 0) begin
            w = exp_q[l].pop_front();
            chk("out_data", out_data[l] == w, out_data[l], w);
            got[l].push_back(out_data[l]);
          end
        end
        stall[l]  = out_valid[l] && !out_ready[l];
        last_d[l] = out_data[l];
        occ_m[l]  = occ_m[l] + int'(r) - int'(dq);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int l, input int v);
    push_en[l]  = 1'b1;
    push_val[l] = W'(v);
    tick();
    push_en[l]  = 1'b0;
  endtask

  task automatic start_burst(input int l, input int bl);
    int n;
    n = (bl == 0 || bl > sp[l]) ? sp[l] : bl;
    for (int i = 0; i < n; i++) exp_q[l].push_back(stk[l][sp[l]-1-i]);
    rds[l]   = 0;
    dones[l] = 0;
    got[l].delete();
    blen[l]  = CW'(bl);
    start[l] = 1'b1;
    tick();
    start[l] = 1'b0;
    @(negedge clk);
    #1;
    chk("busy_after_start", busy[l] == 1'b1, busy[l], 1);
  endtask

  task automatic lat_run(input int l, input int nw, input int want);
    int n = 1;
    while (!out_valid[l] && n < 20) begin
      @(posedge clk); #1; @(negedge clk); #1;
      n++;
    end
    chk("first_valid_lat", n == want, n, want);
    for (int i = 0; i < nw; i++) begin
      chk("back_to_back", out_valid[l] == 1'b1, out_valid[l], 1);
      @(posedge clk); #1; @(negedge clk); #1;
    end
  endtask

  task automatic finish(input int l, input int n, input int remain,
                        input bit pat, output int cyc);
    int k = 0;
    while (!done[l] && k < 300) begin
      @(posedge clk); #1;
      if (pat) out_ready[l] = (k % 4 == 0) || (k % 4 == 3);
      @(negedge clk); #1;
      k++;
    end
    cyc = k + 1;
    chk("done_timeout", done[l] == 1'b1, done[l], 1);
    chk("busy_at_done", busy[l] == 1'b0, busy[l], 0);
    chk("popped_cnt", int'(pcnt[l]) == n, pcnt[l], n);
    chk("read_pulses", rds[l] == n, rds[l], n);
    chk("stack_left", sp[l] == remain, sp[l], remain);
    chk("words_missing", exp_q[l].size() == 0, exp_q[l].size(), 0);
    out_ready[l] = 1'b1;
    @(posedge clk); #1; @(negedge clk); #1;
    chk("done_one_cycle", done[l] == 1'b0, done[l], 0);
    chk("done_count", dones[l] == 1, dones[l], 1);
  endtask

  initial begin
    int cyc;
    reset     = 1'b1;
    start     = '0;
    out_ready = 2'b11;
    push_en   = '0;
    blen      = '{default: '0};
    push_val  = '{default: '0};
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk); #1;
    for (int l = 0; l < 2; l++) begin
      chk("rst_stk_read", stk_read[l] == 1'b0, stk_read[l], 0);
      chk("rst_out_valid", out_valid[l] == 1'b0, out_valid[l], 0);
      chk("rst_out_data", out_data[l] == '0, out_data[l], 0);
      chk("rst_busy", busy[l] == 1'b0, busy[l], 0);
      chk("rst_done", done[l] == 1'b0, done[l], 0);
      chk("rst_popped", pcnt[l] == '0, pcnt[l], 0);
    end

    // RD_LAT=3: eight words, 5-cycle latency then back to back
    for (int v = 1; v <= 8; v++) push(1, v);
    start_burst(1, 0);
    lat_run(1, 8, 5);
    finish(1, 8, 0, 1'b0, cyc);
    chk("lat3_first", got[1].size() > 0 && got[1][0] == 8'd8,
        got[1].size() > 0 ? got[1][0] : -1, 8);

    // 5,6,7 drained until empty
    push(0, 5); push(0, 6); push(0, 7);
    start_burst(0, 0);
    lat_run(0, 3, 3);
    finish(0, 3, 0, 1'b0, cyc);
    chk("t1_words", got[0].size() == 3, got[0].size(), 3);
    if (got[0].size() == 3) begin
      chk("t1_w0", got[0][0] == 8'd7, got[0][0], 7);
      chk("t1_w1", got[0][1] == 8'd6, got[0][1], 6);
      chk("t1_w2", got[0][2] == 8'd5, got[0][2], 5);
    end

    // burst of 3 from 8; start while busy must be ignored
    for (int v = 1; v <= 8; v++) push(0, v);
    start_burst(0, 3);
    start[0] = 1'b1;
    blen[0]  = 4'd1;
    tick();
    start[0] = 1'b0;
    finish(0, 3, 5, 1'b0, cyc);
    chk("t2_words", got[0].size() == 3, got[0].size(), 3);
    if (got[0].size() == 3) begin
      chk("t2_w0", got[0][0] == 8'd8, got[0][0], 8);
      chk("t2_w2", got[0][2] == 8'd6, got[0][2], 6);
    end

    // limited burst longer than the stack stops on empty
    start_burst(0, 15);
    finish(0, 5, 0, 1'b0, cyc);

    // full stack under 1,0,0,1 back-pressure
    for (int v = 1; v <= 8; v++) push(0, v);
    start_burst(0, 0);
    finish(0, 8, 0, 1'b1, cyc);
    chk("t4_words", got[0].size() == 8, got[0].size(), 8);
    if (got[0].size() == 8) begin
      chk("t4_first", got[0][0] == 8'd8, got[0][0], 8);
      chk("t4_last", got[0][7] == 8'd1, got[0][7], 1);
    end

    // empty stack
    start_burst(0, 4);
    finish(0, 0, 0, 1'b0, cyc);
    chk("empty_done_cycles", cyc <= 3, cyc, 3);

    // reset after two pops, then drain the rest
    for (int v = 11; v <= 16; v++) push(0, v);
    start_burst(0, 0);
    cyc = 0;
    while (rds[0] < 2 && cyc < 20) begin
      @(posedge clk); #1; @(negedge clk); #1;
      cyc++;
    end
    chk("two_pops_seen", rds[0] == 2, rds[0], 2);
    @(posedge clk); #1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk); #1;
    chk("rst_mid_busy", busy[0] == 1'b0, busy[0], 0);
    chk("rst_mid_valid", out_valid[0] == 1'b0, out_valid[0], 0);
    chk("rst_mid_read", stk_read[0] == 1'b0, stk_read[0], 0);
    chk("rst_mid_done", dones[0] == 0 && done[0] == 1'b0, dones[0], 0);
    chk("rst_mid_left", sp[0] == 4, sp[0], 4);
    start_burst(0, 0);
    finish(0, 4, 0, 1'b0, cyc);
    chk("t6_first", got[0].size() > 0 && got[0][0] == 8'd14,
        got[0].size() > 0 ? got[0][0] : -1, 14);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/lifo_drain_ctrl.md
Name: lifo_drain_ctrl

Overview:
Downstream consumer of the 8-deep LIFO stack. On a start command it pops a programmable number of words, or pops until the stack is empty. Each popped word goes out on a valid/ready stream. An internal credit-controlled output buffer absorbs the stack's read latency, so back-pressure never drops or duplicates a word.

Parameters:
WIDTH, 8, data word width; must equal the stack data width.
RD_LAT, 1, cycles from stk_read asserted to stk_data valid; legal range 0..3.
CNT_W, 4, width of burst_len and popped_cnt.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  one-cycle pulse that begins a drain burst; ignored while busy=1.
burst_len  input  CNT_W  words to pop, sampled when start is accepted; 0 means drain until empty.
stk_empty  input  1  stack empty flag.
stk_read  output  1  pop request to the stack.
stk_data  input  WIDTH  popped word, valid RD_LAT cycles after stk_read.
out_valid  output  1  out_data holds a valid word.
out_ready  input  1  consumer accepts the word when out_valid && out_ready.
out_data  output  WIDTH  head word of the output buffer.
busy  output  1  high from start acceptance until done.
done  output  1  one-cycle pulse when the burst is fully delivered.
popped_cnt  output  CNT_W  words popped in the current or last burst.

Behaviour:
- Reset values: state IDLE, stk_read=0, out_valid=0, out_data=0, busy=0, done=0, popped_cnt=0. The output buffer is emptied and the in-flight counter is cleared.
- Reset mid-burst: in-flight stk_data returns are discarded and the buffer is flushed. No done pulse is generated.
- States:
  - IDLE: start moves to DRAIN on the next edge. remaining <= burst_len; unlimited flag <= (burst_len==0); popped_cnt <= 0; busy <= 1.
  - DRAIN: issue pops.
  - FLUSH: wait for in-flight returns and for the buffer to drain.
- stk_read is combinational and asserts iff all of the following hold:
  - state==DRAIN;
  - !stk_empty;
  - remaining!=0 or unlimited;
  - inflight + occupancy < RD_LAT+2.
  - The credit check uses registered counts and takes no credit for a same-cycle dequeue.
- Each stk_read:
  - increments inflight and popped_cnt;
  - decrements remaining when the burst is not unlimited;
  - popped_cnt saturates at 2^CNT_W-1.
- Return path:
  - A delay line of RD_LAT stages tags returns. The word is written into the buffer in the cycle its tag emerges, and inflight is decremented in the same cycle.
  - When RD_LAT=0, stk_data is captured in the same cycle as stk_read.
- Output buffer:
  - FIFO of depth RD_LAT+2.
  - out_valid = occupancy!=0; out_data = head entry.
  - Simultaneous enqueue and dequeue leave occupancy unchanged.
  - Overflow is impossible by construction; the bench asserts it never occurs.
- DRAIN to FLUSH transition happens when either:
  - the burst is limited and remaining==0 after the current pop; or
  - stk_empty=1 and no stk_read is issued this cycle.
- Stack empty at start: DRAIN lasts one cycle with zero pops.
- FLUSH to IDLE transition:
  - Taken when inflight==0 and occupancy==0, or when occupancy==1 with that word dequeued this cycle.
  - On the same edge: done=1 for one cycle, busy <= 0, popped_cnt holds its final value.
- Throughput: one word per cycle whenever out_ready=1 and the stack is non-empty, for any legal RD_LAT.
- Latency from start to the first out_valid is RD_LAT+2 cycles with RD_LAT≥1 (one cycle when RD_LAT=0, plus one for the IDLE-to-DRAIN transition).
- Ordering: words leave in pop order, which is LIFO order (top of stack first).
- out_valid held with out_ready=0: out_data must stay stable until accepted.
- start during busy: ignored, with no effect on counters.

Test Plan:
- Push 5,6,7 into the LIFO, then start with burst_len=0 and out_ready=1 -> outputs 7,6,5 on consecutive cycles; done pulses once; popped_cnt=3; stk_empty=1 afterwards.
- Push 8 words 1..8, then start with burst_len=3 -> outputs 8,7,6; stk_read asserted exactly 3 cycles; 5 words remain; done pulses; popped_cnt=3.
- Full stack, burst_len=0, out_ready toggled 1,0,0,1 repeatedly -> all 8 words delivered in order 8..1 with no loss or duplicates. Occupancy never exceeds RD_LAT+2, and out_data is stable while stalled.
- Empty stack, start with burst_len=4 -> zero stk_read pulses; done within 3 cycles; popped_cnt=0; out_valid never rises.
- RD_LAT=3, 8 words, out_ready=1 -> first out_valid 5 cycles after start, then 8 words back-to-back in LIFO order.
- Assert reset mid-burst after 2 pops -> next cycle busy=0, out_valid=0, stk_read=0, no done pulse. A new start drains the remaining words correctly.
